// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU/DIV/DIVU run one radix-2 step per clock for WIDTH clocks, then a
// final sign-fix clock writes HI/LO and pulses done. MTHI/MTLO write directly
// from IDLE. flush cancels an operation in flight without touching HI/LO.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Operation context captured at acceptance.
  logic             is_div_r;
  logic             neg_res_r;
  logic             neg_rem_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] orig_a_r;
  logic [CW-1:0]    count_r;

  // Shared accumulator pair: for multiply {acc_hi,acc_lo} is the shifting
  // product (multiplier starts in acc_lo); for divide acc_hi is the partial
  // remainder and acc_lo shifts the dividend out while quotient bits shift in.
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;

  logic             signed_op_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_sub_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Operand conditioning: signed ops iterate on magnitudes.
  always_comb begin
    signed_op_s = (op == 3'd0) || (op == 3'd2);
    abs_a_s     = a;
    abs_b_s     = b;
    if (signed_op_s && a[WIDTH-1]) begin
      abs_a_s = {WIDTH{1'b0}} - a;
    end else begin
      abs_a_s = a;
    end
    if (signed_op_s && b[WIDTH-1]) begin
      abs_b_s = {WIDTH{1'b0}} - b;
    end else begin
      abs_b_s = b;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
    div_sh_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_ge_s  = (div_sh_s >= {1'b0, opb_r});
    div_sub_s = div_sh_s[WIDTH-1:0] - opb_r;
    step_hi_s = acc_hi_r;
    step_lo_s = acc_lo_r;
    if (is_div_r) begin
      if (div_ge_s) begin
        step_hi_s = div_sub_s;
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = div_sh_s[WIDTH-1:0];
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Final sign correction of the magnitude results.
  always_comb begin
    prod_s     = {acc_hi_r, acc_lo_r};
    prod_fix_s = prod_s;
    quot_fix_s = acc_lo_r;
    rem_fix_s  = acc_hi_r;
    if (neg_res_r) begin
      prod_fix_s = {(2*WIDTH){1'b0}} - prod_s;
      quot_fix_s = {WIDTH{1'b0}} - acc_lo_r;
    end else begin
      prod_fix_s = prod_s;
      quot_fix_s = acc_lo_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = {WIDTH{1'b0}} - acc_hi_r;
    end else begin
      rem_fix_s = acc_hi_r;
    end
  end

  // Control FSM with registered busy/done/HI/LO; reset beats flush beats start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      opa_r      <= {WIDTH{1'b0}};
      opb_r      <= {WIDTH{1'b0}};
      orig_a_r   <= {WIDTH{1'b0}};
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (flush) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              case (op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                  opa_r      <= abs_a_s;
                  opb_r      <= abs_b_s;
                  orig_a_r   <= a;
                  is_div_r   <= op[1];
                  neg_res_r  <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_r  <= signed_op_s && a[WIDTH-1];
                  div_zero_r <= (b == {WIDTH{1'b0}});
                  acc_hi_r   <= {WIDTH{1'b0}};
                  acc_lo_r   <= op[1] ? abs_a_s : abs_b_s;
                  count_r    <= {CW{1'b0}};
                  state_r    <= CALC;
                  busy_r     <= 1'b1;
                end
                3'd4:    hi_r <= a;
                3'd5:    lo_r <= a;
                default: state_r <= IDLE;
              endcase
            end
          end
          CALC: begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
            if (count_r == CW'(WIDTH - 1)) begin
              state_r <= SIGN;
            end
          end
          SIGN: begin
            if (is_div_r) begin
              if (div_zero_r) begin
                hi_r <= orig_a_r;
                lo_r <= {WIDTH{1'b1}};
              end else begin
                hi_r <= rem_fix_s;
                lo_r <= quot_fix_s;
              end
            end else begin
              hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix_s[WIDTH-1:0];
            end
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit (WIDTH=32).
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int fails = 0;
  int busy_cycles;
  int done_seen;
  int done_count;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at the next edge, then drop start just after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge: counts busy cycles until done, bounded.
  task automatic wait_done();
    busy_cycles = 0;
    done_seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) begin
        done_seen = 1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, av, bv);
    wait_done();
    check({tag, "_done"}, 64'(done_seen), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk); resetn = 1'b1;

    // MULT -3*5 with latency and single-cycle done pulse
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_done();
    check("mult_busy_cycles", 64'(busy_cycles), 64'd33);
    check("mult_done", 64'(done_seen), 64'd1);
    check("mult_busy_at_done", 64'(busy), 64'd0);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFF1);
    @(posedge clk); #1;
    check("mult_done_pulse", 64'(done), 64'd0);

    run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("mult_negneg", 3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    run("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run("div_by0", 3'd2, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run("div_neg_by0", 3'd2, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // Start accepted on the edge right after done (done cycle has busy low)
    issue(3'd3, 32'd9, 32'd4);
    wait_done();
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done();
    check("b2b_done", 64'(done_seen), 64'd1);
    check("b2b_hi", 64'(hi), 64'd0);
    check("b2b_lo", 64'(lo), 64'd12);

    // MULT, ignored MTLO while busy, flush at cycle 10
    issue(3'd0, 32'd7, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_count++;
    end
    check("flush_no_done", 64'(done_count), 64'd0);
    check("flush_hi", 64'(hi), 64'd0);
    check("flush_lo", 64'(lo), 64'd12);

    // MTHI/MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h0000AAAA;
    @(posedge clk); #1;
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    op = 3'd5; a = 32'h00005555;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);
    check("mthi_hi", 64'(hi), 64'h0000AAAA);
    check("mtlo_lo", 64'(lo), 64'h00005555);

    // flush in IDLE blocks MTHI; op 6 is a no-op
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h77777777; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("idle_flush_hi", 64'(hi), 64'h0000AAAA);
    issue(3'd6, 32'h12345678, 32'd1);
    check("op6_busy", 64'(busy), 64'd0);
    check("op6_hi", 64'(hi), 64'h0000AAAA);
    check("op6_lo", 64'(lo), 64'h00005555);

    // Reset in the middle of a DIV
    issue(3'd2, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    @(negedge clk); resetn = 1'b1;
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_count++;
    end
    check("rst_mid_no_done", 64'(done_count), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
